// File: rtl/rr_xout_arbiter.sv
// Round-robin arbiter that serializes NREQ byte requesters onto one registered
// output byte, holding each granted byte valid for HOLD_CYCLES cycles.
module rr_xout_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [NREQ-1:0]         REQ,
  input  logic [8*NREQ-1:0]       DIN,
  output logic [NREQ-1:0]         ACK,
  output logic [7:0]              XOUT,
  output logic                    XVALID,
  output logic [$clog2(NREQ)-1:0] GNT_ID
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   gnt_d;
  logic [NREQ-1:0]   ack_d;
  logic [7:0]        xout_d;
  logic              xvalid_d;

  logic              sel_found;
  logic [ID_W-1:0]   sel_id;
  logic [7:0]        din_sel;

  // Rotating priority scan starting just after the last winner; scanning the
  // offsets high-to-low leaves the nearest requester as the final choice.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      idx  = (int'(last_q) + k) % NREQ;
      cand = ID_W'(idx);
      if (REQ[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Byte of the selected requester.
  always_comb begin
    din_sel = 8'h00;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (sel_id == ID_W'(i)) din_sel = DIN[8*i +: 8];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = GNT_ID;
    xout_d   = XOUT;
    ack_d    = '0;
    xvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ENABLE && sel_found) begin
          state_d  = HOLD;
          cnt_d    = CNT_W'(HOLD_CYCLES - 1);
          last_d   = sel_id;
          gnt_d    = sel_id;
          xout_d   = din_sel;
          ack_d    = NREQ'(1) << sel_id;
          xvalid_d = 1'b1;
        end
      end
      HOLD: begin
        xvalid_d = 1'b1;
        if (cnt_q == '0) begin
          state_d  = IDLE;
          xvalid_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= ID_W'(NREQ - 1);
      GNT_ID  <= '0;
      XOUT    <= 8'h00;
      ACK     <= '0;
      XVALID  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      GNT_ID  <= gnt_d;
      XOUT    <= xout_d;
      ACK     <= ack_d;
      XVALID  <= xvalid_d;
    end
  end

endmodule

// File: tb/tb_rr_xout_arbiter.sv
// Directed bench for rr_xout_arbiter (NREQ=4, HOLD_CYCLES=3) with
// hand-computed expectations checked by immediate assertions.
module tb_rr_xout_arbiter;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic [3:0]  REQ;
  logic [31:0] DIN;
  logic [3:0]  ACK;
  logic [7:0]  XOUT;
  logic        XVALID;
  logic [1:0]  GNT_ID;

  int tests = 0;
  int fails = 0;

  rr_xout_arbiter #(.NREQ(4), .HOLD_CYCLES(3)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .REQ    (REQ),
    .DIN    (DIN),
    .ACK    (ACK),
    .XOUT   (XOUT),
    .XVALID (XVALID),
    .GNT_ID (GNT_ID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full output set right after a grant edge.
  task automatic chk_grant(input string tag, input logic [7:0] x, input logic [1:0] id);
    chk({tag, "_xout"},   32'(XOUT),   32'(x));
    chk({tag, "_gnt"},    32'(GNT_ID), 32'(id));
    chk({tag, "_ack"},    32'(ACK),    32'(4'b0001 << id));
    chk({tag, "_xvalid"}, 32'(XVALID), 32'd1);
  endtask

  initial begin
    logic [7:0] seq [5];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h11;

    // 1: reset
    RESET = 1'b1; ENABLE = 1'b1; REQ = 4'b0000; DIN = 32'h0;
    step();
    chk("rst_xout",   32'(XOUT),   32'h00);
    chk("rst_xvalid", 32'(XVALID), 32'd0);
    chk("rst_ack",    32'(ACK),    32'd0);
    chk("rst_gnt",    32'(GNT_ID), 32'd0);
    RESET = 1'b0;
    step(); step();
    chk("idle_xvalid", 32'(XVALID), 32'd0);
    chk("idle_xout",   32'(XOUT),   32'h00);

    // 2: single requester 2
    REQ = 4'b0100; DIN = 32'h00A5_0000;
    step();
    chk_grant("single", 8'hA5, 2'd2);
    REQ = 4'b0000;
    step();
    chk("single_ack_pulse", 32'(ACK),    32'd0);
    chk("single_hold2",     32'(XVALID), 32'd1);
    step();
    chk("single_hold3",     32'(XVALID), 32'd1);
    chk("single_xout_hold", 32'(XOUT),   32'hA5);
    step();
    chk("single_end",       32'(XVALID), 32'd0);
    chk("single_xout_keep", 32'(XOUT),   32'hA5);
    chk("single_gnt_keep",  32'(GNT_ID), 32'd2);

    // 3: all request continuously from a fresh reset
    RESET = 1'b1;
    step();
    RESET = 1'b0; REQ = 4'b1111; DIN = 32'h4433_2211;
    for (int g = 0; g < 5; g++) begin
      step();
      chk_grant($sformatf("rr%0d", g), seq[g], 2'(g % 4));
      step();
      chk($sformatf("rr%0d_h2", g), 32'(XVALID), 32'd1);
      chk($sformatf("rr%0d_ack0", g), 32'(ACK), 32'd0);
      step();
      chk($sformatf("rr%0d_h3", g), 32'(XVALID), 32'd1);
      step();
      chk($sformatf("rr%0d_gap", g), 32'(XVALID), 32'd0);
    end

    // 4: wrap after a grant to 3
    REQ = 4'b1000;
    step();
    chk_grant("wrap_g3", 8'h44, 2'd3);
    REQ = 4'b1001;
    step(); step(); step();
    chk("wrap_gap", 32'(XVALID), 32'd0);
    step();
    chk_grant("wrap_g0", 8'h11, 2'd0);
    step(); step(); step();
    step();
    chk_grant("wrap_g3b", 8'h44, 2'd3);
    REQ = 4'b0000;
    step(); step(); step();
    chk("wrap_done", 32'(XVALID), 32'd0);

    // 5: ENABLE low blocks grants
    ENABLE = 1'b0; REQ = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("dis%0d_xvalid", c), 32'(XVALID), 32'd0);
    end
    chk("dis_ack", 32'(ACK), 32'd0);
    ENABLE = 1'b1;
    step();
    chk_grant("en_g1", 8'h22, 2'd1);
    REQ = 4'b0000;

    // 6: reset in second hold cycle
    step();
    chk("rsthold_pre", 32'(XVALID), 32'd1);
    RESET = 1'b1;
    step();
    chk("rsthold_xout",   32'(XOUT),   32'h00);
    chk("rsthold_xvalid", 32'(XVALID), 32'd0);
    chk("rsthold_ack",    32'(ACK),    32'd0);
    chk("rsthold_gnt",    32'(GNT_ID), 32'd0);
    RESET = 1'b0; REQ = 4'b1111;
    step();
    chk_grant("post_rst", 8'h11, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
